// File: rtl/adder_result_checker.sv
// Checks a stream of adder (a, b, sum, carry) records against a + b; reports pass/fail after num_vectors beats.
// Results visible the cycle after the accepting edge; never stalls in RUN. Carry checking under CHK_CARRY_EN.
module adder_result_checker #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_sum,
  input  logic             in_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [W-1:0]     first_err_a,
  output logic [W-1:0]     first_err_b,
  output logic [W-1:0]     first_err_sum,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] vec_idx;
  logic [W:0]       expected;
  logic             mismatch;
  logic             beat;
  logic             last_beat;
  logic             start_ok;

  assign expected = {1'b0, in_a} + {1'b0, in_b};

`ifdef CHK_CARRY_EN
  assign mismatch = (in_sum != expected[W-1:0]) || (in_carry != expected[W]);
`else
  logic unused_carry;
  assign unused_carry = in_carry ^ expected[W];
  assign mismatch     = (in_sum != expected[W-1:0]);
`endif

  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (vec_idx == num_lat - CNT_W'(1));
  // start is only honoured outside RUN
  assign start_ok  = start && (state != RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (num_vectors == '0) ? DONE : RUN;
      RUN:        if (last_beat) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      num_lat         <= '0;
      vec_idx         <= '0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_sum   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        num_lat         <= num_vectors;
        vec_idx         <= '0;
        err_count       <= '0;
        first_err_idx   <= '0;
        first_err_a     <= '0;
        first_err_b     <= '0;
        first_err_sum   <= '0;
        first_err_valid <= 1'b0;
      end else if (beat) begin
        vec_idx <= vec_idx + CNT_W'(1);
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
          if (!first_err_valid) begin
            first_err_idx   <= vec_idx;
            first_err_a     <= in_a;
            first_err_b     <= in_b;
            first_err_sum   <= in_sum;
            first_err_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Randomized self-checking bench for adder_result_checker against a record-list reference model.
module tb_adder_result_checker;

  localparam int W     = 8;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a, in_b, in_sum;
  logic             in_carry;
  logic             busy, done, pass;
  logic [CNT_W-1:0] err_count, first_err_idx;
  logic [W-1:0]     first_err_a, first_err_b, first_err_sum;
  logic             first_err_valid;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] qa[$], qb[$], qs[$];
  logic         qc[$];

  adder_result_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sum(in_sum), .in_carry(in_carry), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .first_err_a(first_err_a),
    .first_err_b(first_err_b), .first_err_sum(first_err_sum),
    .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a record is bad when the sum (and optionally the carry) disagrees with integer a+b.
  function automatic bit is_bad(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] s, input logic c);
    int t;
    t = int'(a) + int'(b);
`ifdef CHK_CARRY_EN
    return (int'(s) != (t % 256)) || (int'(c) != (t / 256));
`else
    return (int'(s) != (t % 256));
`endif
  endfunction

  task automatic add(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] s, input logic c);
    qa.push_back(a); qb.push_back(b); qs.push_back(s); qc.push_back(c);
  endtask

  task automatic gen(input int n, input int bad_pct);
    for (int k = 0; k < n; k++) begin
      logic [W-1:0] a, b, s;
      logic [W:0]   t;
      logic         c;
      a = W'($urandom);
      b = W'($urandom);
      t = a + b;
      s = t[W-1:0];
      c = t[W];
      if (int'($urandom_range(99)) < bad_pct) begin
        if ($urandom_range(3) == 0) c = ~c;
        else s = s ^ W'($urandom_range(255, 1));
      end
      add(a, b, s, c);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_rdy"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_errc"}, err_count, 0);
    check({tag, "_fidx"}, first_err_idx, 0);
    check({tag, "_fa"}, first_err_a, 0);
    check({tag, "_fb"}, first_err_b, 0);
    check({tag, "_fs"}, first_err_sum, 0);
    check({tag, "_fv"}, first_err_valid, 0);
  endtask

  // Drives the queued records as one run and checks progress and final results.
  task automatic run(input int n, input bit gaps, input bit mid_start);
    int i = 0, cyc = 0, errs = 0, first = -1;
    bit acc;
    @(negedge clk);
    start = 1'b1;
    num_vectors = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, n != 0);
    check("rdy_after_start", in_ready, n != 0);
    check("err_cleared", err_count, 0);
    while (i < n && cyc < n * 4 + 20) begin
      in_valid = gaps ? (cyc % 3 == 0) : 1'b1;
      in_a = qa[i]; in_b = qb[i]; in_sum = qs[i]; in_carry = qc[i];
      if (mid_start && cyc == 1) begin
        start = 1'b1;
        num_vectors = CNT_W'(200);
      end
      check("rdy_in_run", in_ready, 1);
      acc = in_valid && in_ready;
      @(negedge clk);
      start = 1'b0;
      if (acc) begin
        if (is_bad(qa[i], qb[i], qs[i], qc[i])) begin
          errs++;
          if (first < 0) first = i;
        end
        i++;
      end
      check("err_running", err_count, (errs > SAT) ? SAT : errs);
      check("done_flag", done, i == n);
      check("busy_flag", busy, i < n);
      cyc++;
    end
    in_valid = 1'b0;
    check("beats", i, n);
    check("final_done", done, 1);
    check("final_rdy", in_ready, 0);
    check("final_pass", pass, errs == 0);
    check("final_errc", err_count, (errs > SAT) ? SAT : errs);
    check("final_fv", first_err_valid, first >= 0);
    check("final_fidx", first_err_idx, (first >= 0) ? first : 0);
    check("final_fa", first_err_a, (first >= 0) ? qa[first] : 0);
    check("final_fb", first_err_b, (first >= 0) ? qb[first] : 0);
    check("final_fs", first_err_sum, (first >= 0) ? qs[first] : 0);
    qa.delete(); qb.delete(); qs.delete(); qc.delete();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_vectors = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_sum = '0; in_carry = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    add(8'h01, 8'h02, 8'h03, 1'b0);
    add(8'hFF, 8'h01, 8'h00, 1'b1);
    add(8'h80, 8'h80, 8'h00, 1'b1);
    run(3, 1'b0, 1'b0);

    gen(2, 0);
    add(8'h10, 8'h20, 8'h31, 1'b0);
    gen(1, 0);
    run(4, 1'b0, 1'b0);

    add(8'hFF, 8'h01, 8'h00, 1'b0);
    run(1, 1'b0, 1'b0);

    gen(5, 40);
    run(5, 1'b1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(20, 1));
      gen(n, 30);
      run(n, k[0], 1'b0);
    end

    for (int k = 0; k < SAT; k++) begin
      logic [W-1:0] a, b, s;
      a = W'($urandom);
      b = W'($urandom);
      s = (a + b) ^ W'($urandom_range(255, 1));
      add(a, b, s, 1'b0);
    end
    run(SAT, 1'b0, 1'b0);

    gen(2, 0);
    run(2, 1'b0, 1'b0);

    // reset in the middle of a 6-beat run
    gen(6, 50);
    @(negedge clk);
    start = 1'b1;
    num_vectors = CNT_W'(6);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_a = qa[k]; in_b = qb[k]; in_sum = qs[k]; in_carry = qc[k];
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    in_valid = 1'b0;
    reset = 1'b1;
    qa.delete(); qb.delete(); qs.delete(); qc.delete();
    @(negedge clk);
    run(0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
